cp0_exc_unit: RTL and testbench

- Coprocessor-0 exception and control block for the 5-stage MIPS core.
- Consumes the ALU arithmetic-overflow flag and the decoder's exception flags.
- Prioritises exception causes, records EPC/Cause/Status, and issues a one-cycle pipeline flush plus redirect PC; also serves MFC0/MTC0/ERET.
- Contains the Count/Compare timer that raises hardware interrupt 5 (IP7).

---
 rtl/cp0_pkg.sv | 41 ++++
 rtl/cp0_timer.sv | 48 ++++
 rtl/cp0_exc_unit.sv | 146 ++++++++++++++
 tb/tb_cp0_exc_unit.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, Status/Cause bit
// positions and the default exception vector.
package cp0_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    typedef enum logic [4:0] {
        EXC_INT = 5'h00,
        EXC_SYS = 5'h08,
        EXC_BP  = 5'h09,
        EXC_RI  = 5'h0A,
        EXC_OV  = 5'h0C
    } exc_code_e;

    localparam int ST_BEV      = 22;
    localparam int ST_IM_LO    = 8;
    localparam int ST_EXL      = 1;
    localparam int ST_IE       = 0;
    localparam int CA_BD       = 31;
    localparam int CA_TI       = 30;
    localparam int CA_IP_LO    = 8;
    localparam int CA_CODE_LO  = 2;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;
    localparam logic [31:0] STATUS_RST_DEF = 32'h0040_0000;

    // Interrupt outranks every synchronous cause; overflow is the fallback.
    function automatic exc_code_e exc_prio(input logic intr, input logic ri,
                                           input logic sys, input logic bp);
        if (intr)     return EXC_INT;
        else if (ri)  return EXC_RI;
        else if (sys) return EXC_SYS;
        else if (bp)  return EXC_BP;
        else          return EXC_OV;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running Count with wrap, Compare match latches TI
// until software rewrites Compare.
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we_count,
    input  logic        we_compare,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;

    // A Compare write both reloads the target and acknowledges a pending tick.
    always_comb begin
        count_d   = we_count ? wdata : count_q + 32'd1;
        compare_d = we_compare ? wdata : compare_q;
        ti_d      = ti_q;
        if (we_compare) begin
            ti_d = 1'b0;
        end else if (compare_q != 32'd0 && count_q == compare_q) begin
            ti_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 exception/control unit: prioritises causes, records EPC/Cause/Status,
// issues a one-cycle flush with redirect, and serves MFC0/MTC0/ERET.
module cp0_exc_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter logic [31:0] STATUS_RST = STATUS_RST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    input  logic [31:0] inst_pc,
    input  logic        in_delay_slot,
    input  logic        exc_ov,
    input  logic        exc_sys,
    input  logic        exc_bp,
    input  logic        exc_ri,
    input  logic        eret,
    input  logic        mtc0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [31:0] epc_out,
    output logic [31:0] status_out,
    output logic [31:0] cause_out
);

    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [1:0]  sw_ip_q, sw_ip_d;
    exc_code_e   code_q, code_d;
    logic [31:0] epc_q, epc_d;
    logic        flush_q, flush_d;
    logic [31:0] redirect_q, redirect_d;

    logic [31:0] count, compare;
    logic        ti;
    logic [7:0]  ip;
    logic        int_pend, sync_exc, take_exc, take_eret, cp0_we;

    assign ip        = {ti, 5'b0, sw_ip_q};
    assign int_pend  = inst_valid & ie_q & ~exl_q & (|(im_q & ip));
    assign sync_exc  = inst_valid & (exc_ri | exc_sys | exc_bp | exc_ov);
    assign take_exc  = int_pend | sync_exc;
    assign take_eret = inst_valid & eret & ~take_exc;
    assign cp0_we    = inst_valid & mtc0_we & ~take_exc;

    cp0_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .we_count   (cp0_we && cp0_addr == CP0_COUNT),
        .we_compare (cp0_we && cp0_addr == CP0_COMPARE),
        .wdata      (cp0_wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    // A nested exception (EXL already set) must not clobber the original EPC/BD.
    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        sw_ip_d    = sw_ip_q;
        code_d     = code_q;
        epc_d      = epc_q;
        flush_d    = 1'b0;
        redirect_d = redirect_q;

        if (take_exc) begin
            if (!exl_q) begin
                epc_d = in_delay_slot ? inst_pc - 32'd4 : inst_pc;
                bd_d  = in_delay_slot;
            end
            exl_d      = 1'b1;
            code_d     = exc_prio(int_pend, exc_ri, exc_sys, exc_bp);
            flush_d    = 1'b1;
            redirect_d = EXC_VECTOR;
        end else if (take_eret) begin
            exl_d      = 1'b0;
            flush_d    = 1'b1;
            redirect_d = epc_q;
        end

        if (cp0_we) begin
            case (cp0_addr)
                CP0_STATUS: begin
                    im_d  = cp0_wdata[ST_IM_LO +: 8];
                    exl_d = cp0_wdata[ST_EXL];
                    ie_d  = cp0_wdata[ST_IE];
                end
                CP0_CAUSE: sw_ip_d = cp0_wdata[CA_IP_LO +: 2];
                CP0_EPC:   epc_d   = cp0_wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            im_q       <= STATUS_RST[ST_IM_LO +: 8];
            exl_q      <= STATUS_RST[ST_EXL];
            ie_q       <= STATUS_RST[ST_IE];
            bd_q       <= 1'b0;
            sw_ip_q    <= 2'b0;
            code_q     <= EXC_INT;
            epc_q      <= '0;
            flush_q    <= 1'b0;
            redirect_q <= '0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            sw_ip_q    <= sw_ip_d;
            code_q     <= code_d;
            epc_q      <= epc_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
        end
    end

    assign status_out  = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign cause_out   = {bd_q, ti, 14'b0, ip, 1'b0, code_q, 2'b0};
    assign epc_out     = epc_q;
    assign flush       = flush_q;
    assign redirect_pc = redirect_q;

    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            CP0_COUNT:   cp0_rdata = count;
            CP0_COMPARE: cp0_rdata = compare;
            CP0_STATUS:  cp0_rdata = status_out;
            CP0_CAUSE:   cp0_rdata = cause_out;
            CP0_EPC:     cp0_rdata = epc_q;
            default:     cp0_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Scoreboard bench for cp0_exc_unit: directed scenarios then random traffic,
// checked against an architectural model of the CP0 registers.
module tb_cp0_exc_unit;

    logic        clk;
    logic        rst;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic        in_delay_slot;
    logic        exc_ov, exc_sys, exc_bp, exc_ri;
    logic        eret;
    logic        mtc0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] epc_out, status_out, cause_out;

    cp0_exc_unit dut (
        .clk           (clk),
        .rst           (rst),
        .inst_valid    (inst_valid),
        .inst_pc       (inst_pc),
        .in_delay_slot (in_delay_slot),
        .exc_ov        (exc_ov),
        .exc_sys       (exc_sys),
        .exc_bp        (exc_bp),
        .exc_ri        (exc_ri),
        .eret          (eret),
        .mtc0_we       (mtc0_we),
        .cp0_addr      (cp0_addr),
        .cp0_wdata     (cp0_wdata),
        .cp0_rdata     (cp0_rdata),
        .flush         (flush),
        .redirect_pc   (redirect_pc),
        .epc_out       (epc_out),
        .status_out    (status_out),
        .cause_out     (cause_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        valid;
        logic [31:0] pc;
        logic        ds;
        logic        ov, sys, bp, ri;
        logic        eret;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
    } stim_t;

    typedef struct packed {
        logic        flush;
        logic [31:0] redir;
        logic [31:0] epc;
        logic [31:0] status;
        logic [31:0] cause;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Architectural state of the reference model
    bit          m_init = 0;
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_bd, m_ti, m_flush;
    logic [1:0]  m_sw;
    logic [4:0]  m_code;
    logic [31:0] m_epc, m_count, m_compare, m_redir;

    function automatic logic [31:0] m_status();
        return 32'h0040_0000 | ({24'b0, m_im} << 8) | ({31'b0, m_exl} << 1) | {31'b0, m_ie};
    endfunction

    function automatic logic [31:0] m_cause();
        return ({31'b0, m_bd} << 31) | ({31'b0, m_ti} << 30) | ({31'b0, m_ti} << 15)
             | ({30'b0, m_sw} << 8) | ({27'b0, m_code} << 2);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status();
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step(input stim_t s);
        logic [7:0]  ip;
        logic        intp, exc;
        logic [31:0] nxt_count, nxt_compare, old_epc;
        logic        nxt_ti;
        if (s.rst) begin
            m_im = 8'h0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_sw = 2'b0;
            m_code = 5'h0; m_epc = 0; m_count = 0; m_compare = 0;
            m_flush = 0; m_redir = 0; m_init = 1;
            return;
        end
        ip      = {m_ti, 5'b0, m_sw};
        intp    = s.valid && m_ie && !m_exl && ((m_im & ip) != 0);
        exc     = intp || (s.valid && (s.ov || s.sys || s.bp || s.ri));
        old_epc = m_epc;
        nxt_count   = m_count + 1;
        nxt_compare = m_compare;
        nxt_ti      = m_ti;
        if (m_compare != 0 && m_count == m_compare) nxt_ti = 1;
        m_flush = 0;
        if (exc) begin
            if (!m_exl) begin
                m_epc = s.ds ? s.pc - 4 : s.pc;
                m_bd  = s.ds;
            end
            m_exl   = 1;
            m_code  = intp ? 5'h00 : s.ri ? 5'h0A : s.sys ? 5'h08 : s.bp ? 5'h09 : 5'h0C;
            m_flush = 1;
            m_redir = 32'hBFC0_0380;
        end else if (s.valid && s.eret) begin
            m_exl   = 0;
            m_flush = 1;
            m_redir = old_epc;
        end else if (s.valid && s.we) begin
            case (s.addr)
                5'd9:  nxt_count = s.wdata;
                5'd11: begin nxt_compare = s.wdata; nxt_ti = 0; end
                5'd12: begin m_im = s.wdata[15:8]; m_exl = s.wdata[1]; m_ie = s.wdata[0]; end
                5'd13: m_sw = s.wdata[9:8];
                5'd14: m_epc = s.wdata;
                default: ;
            endcase
        end
        m_count   = nxt_count;
        m_compare = nxt_compare;
        m_ti      = nxt_ti;
    endtask

    task automatic compare32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        exp_t e;
        @(negedge clk);
        rst = s.rst; inst_valid = s.valid; inst_pc = s.pc; in_delay_slot = s.ds;
        exc_ov = s.ov; exc_sys = s.sys; exc_bp = s.bp; exc_ri = s.ri;
        eret = s.eret; mtc0_we = s.we; cp0_addr = s.addr; cp0_wdata = s.wdata;
        #1;
        if (m_init) compare32("cp0_rdata", cp0_rdata, m_read(s.addr));
        model_step(s);
        e.flush = m_flush; e.redir = m_redir; e.epc = m_epc;
        e.status = m_status(); e.cause = m_cause();
        sb.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        compare32("flush", {31'b0, flush}, {31'b0, e.flush});
        if (e.flush) compare32("redirect_pc", redirect_pc, e.redir);
        compare32("epc_out", epc_out, e.epc);
        compare32("status_out", status_out, e.status);
        compare32("cause_out", cause_out, e.cause);
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) checkOutput(sb.pop_front());
        end
    end

    function automatic stim_t nop(input logic valid, input logic [4:0] addr);
        stim_t s;
        s = '0;
        s.valid = valid;
        s.addr  = addr;
        s.pc    = 32'h0000_1000;
        return s;
    endfunction

    function automatic stim_t wr(input logic [4:0] addr, input logic [31:0] d);
        stim_t s;
        s = nop(1'b1, addr);
        s.we = 1; s.wdata = d;
        return s;
    endfunction

    initial begin : stimulus
        stim_t s;
        int    r;
        rst = 1; inst_valid = 0; inst_pc = 0; in_delay_slot = 0;
        exc_ov = 0; exc_sys = 0; exc_bp = 0; exc_ri = 0;
        eret = 0; mtc0_we = 0; cp0_addr = 0; cp0_wdata = 0;

        // Reset and read back Status
        for (int i = 0; i < 3; i++) begin s = nop(0, 5'd12); s.rst = 1; applyStimulus(s); end
        applyStimulus(nop(0, 5'd12));
        applyStimulus(nop(0, 5'd13));

        // Overflow at 0x100, then ERET
        s = nop(1, 5'd14); s.ov = 1; s.pc = 32'h100; applyStimulus(s);
        applyStimulus(nop(1, 5'd13));
        s = nop(1, 5'd14); s.eret = 1; applyStimulus(s);
        applyStimulus(nop(1, 5'd12));

        // SYSCALL beats OV in a delay slot
        s = nop(1, 5'd13); s.sys = 1; s.ov = 1; s.ds = 1; s.pc = 32'h204; applyStimulus(s);
        applyStimulus(nop(1, 5'd14));

        // Nested overflow leaves EPC alone; ERET returns to it
        s = nop(1, 5'd14); s.ov = 1; s.pc = 32'h300; applyStimulus(s);
        applyStimulus(nop(1, 5'd14));
        s = nop(1, 5'd12); s.eret = 1; applyStimulus(s);
        applyStimulus(nop(1, 5'd12));

        // Timer interrupt on IP7
        applyStimulus(wr(5'd9, 32'd0));
        applyStimulus(wr(5'd11, 32'd5));
        applyStimulus(wr(5'd12, 32'h0000_8001));
        for (int i = 0; i < 10; i++) applyStimulus(nop(1, 5'd13));
        applyStimulus(wr(5'd11, 32'd0));
        applyStimulus(nop(1, 5'd13));
        s = nop(1, 5'd12); s.eret = 1; applyStimulus(s);

        // MTC0 Status dropped by a coincident RI
        s = wr(5'd12, 32'h0000_0000); s.ri = 1; applyStimulus(s);
        applyStimulus(nop(1, 5'd12));
        s = nop(1, 5'd12); s.eret = 1; applyStimulus(s);

        // Count wraps through zero
        applyStimulus(wr(5'd9, 32'hFFFF_FFFE));
        for (int i = 0; i < 3; i++) applyStimulus(nop(0, 5'd9));

        // Reset during the flush cycle
        s = nop(1, 5'd12); s.ov = 1; applyStimulus(s);
        s = nop(0, 5'd12); s.rst = 1; applyStimulus(s);
        applyStimulus(nop(0, 5'd12));

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            s = '0;
            s.valid = ($urandom_range(0, 99) < 85);
            s.pc    = $urandom & 32'hFFFF_FFFC;
            s.ds    = ($urandom_range(0, 99) < 20);
            s.ov    = ($urandom_range(0, 99) < 4);
            s.sys   = ($urandom_range(0, 99) < 3);
            s.bp    = ($urandom_range(0, 99) < 3);
            s.ri    = ($urandom_range(0, 99) < 3);
            s.rst   = ($urandom_range(0, 999) < 3);
            r = $urandom_range(0, 5);
            case (r)
                0: s.addr = 5'd9;
                1: s.addr = 5'd11;
                2: s.addr = 5'd12;
                3: s.addr = 5'd13;
                4: s.addr = 5'd14;
                default: s.addr = 5'($urandom_range(0, 31));
            endcase
            if ($urandom_range(0, 99) < (m_exl ? 10 : 2)) begin
                s.eret = 1;
            end else if ($urandom_range(0, 99) < 12) begin
                s.we = 1;
                case (s.addr)
                    5'd9:  s.wdata = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : 32'($urandom_range(0, 40));
                    5'd11: s.wdata = ($urandom_range(0, 4) == 0) ? 32'd0 : m_count + 32'($urandom_range(2, 30));
                    5'd12: s.wdata = ($urandom | 32'h0000_8000) & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
                    default: s.wdata = $urandom;
                endcase
            end
            applyStimulus(s);
        end

        applyStimulus(nop(0, 5'd0));
        @(posedge clk);
        #3;
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
